// File: rtl/dmem_coherency_ctrl_pkg.sv
// dmem_coherency_ctrl_pkg: replay-entry layout shared by the coherency controller and its queues.
// An entry is {addr, data, funct3}; the address field is truncated to ADDR_W bits in storage.
package dmem_coherency_ctrl_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int FUNCT3_LSB  = 0;
    localparam int DATA_LSB    = 3;
    localparam int ADDR_LSB    = 35;
    localparam int MAX_ENTRY_W = ADDR_LSB + 32;
    localparam int ENTRY_W     = DEF_ADDR_W + ADDR_LSB;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct3;
    } store_t;

    function automatic logic [MAX_ENTRY_W-1:0] pack_entry(input store_t s);
        logic [MAX_ENTRY_W-1:0] e;
        e = '0;
        e[ADDR_LSB +: 32]  = s.addr;
        e[DATA_LSB +: 32]  = s.data;
        e[FUNCT3_LSB +: 3] = s.funct3;
        return e;
    endfunction

    function automatic store_t unpack_entry(input logic [MAX_ENTRY_W-1:0] e);
        store_t s;
        s.addr   = e[ADDR_LSB +: 32];
        s.data   = e[DATA_LSB +: 32];
        s.funct3 = e[FUNCT3_LSB +: 3];
        return s;
    endfunction

endpackage

// File: rtl/dmem_coherency_ctrl_replay_fifo.sv
// dmem_coherency_ctrl_replay_fifo: circular replay queue with single or double push and single pop.
// push2 only takes effect together with push; din lands first, din2 right behind it.
module dmem_coherency_ctrl_replay_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 43
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         push2,
    input  logic [W-1:0] din,
    input  logic [W-1:0] din2,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr, wptr, wptr1;
    logic [CW-1:0] count;
    logic          do_pop, do_push2;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wptr1    = inc(wptr);
    assign do_pop   = pop & ~empty;
    assign do_push2 = push & push2;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign dout     = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= do_push2 ? inc(wptr1) : wptr1;
            if (do_pop) rptr <= inc(rptr);
            count <= count + CW'(push) + CW'(do_push2) - CW'(do_pop);
        end
    end

    // Storage needs no reset: dout is only consumed while the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
        if (do_push2) mem[wptr1] <= din2;
    end

endmodule

// File: rtl/dmem_coherency_ctrl.sv
// dmem_coherency_ctrl: mirrors every committed store of one rv32i core into the other core's DMEM
// by queueing it and replaying it through the target core's coherency inlet while that core is stalled.
module dmem_coherency_ctrl
    import dmem_coherency_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluOutMem0,
    input  logic [31:0] dataBMem0,
    input  logic [2:0]  funct3Mem0,
    input  logic        dmemWren0,
    input  logic [31:0] aluOutMem1,
    input  logic [31:0] dataBMem1,
    input  logic [2:0]  funct3Mem1,
    input  logic        dmemWren1,
    output logic        extStall0,
    output logic [31:0] aluOutMemC0,
    output logic [31:0] dataBMemC0,
    output logic [2:0]  funct3MemC0,
    output logic        dmemWrenC0,
    output logic        extStall1,
    output logic [31:0] aluOutMemC1,
    output logic [31:0] dataBMemC1,
    output logic [2:0]  funct3MemC1,
    output logic        dmemWrenC1,
    output logic        busy
);

    localparam int EW = ADDR_W + ADDR_LSB;

    store_t        st0, st1, rd0, rd1;
    logic [EW-1:0] ent0, ent1, head0, head1;
    logic          empty0, full0, empty1, full1, acc0, acc1;

    assign st0  = '{aluOutMem0, dataBMem0, funct3Mem0};
    assign st1  = '{aluOutMem1, dataBMem1, funct3Mem1};
    assign ent0 = EW'(pack_entry(st0));
    assign ent1 = EW'(pack_entry(st1));

    // Stalls depend on queue state only, so core strobes never reach the outputs combinationally.
    assign extStall0 = ~empty0 | full1;
    assign extStall1 = ~empty1 | full0;
    assign acc0      = dmemWren0 & ~extStall0;
    assign acc1      = dmemWren1 & ~extStall1;
    assign busy      = ~empty0 | ~empty1;

    // On a collision Q0 takes core 1's store then core 0's, so both memories settle on core 0's value.
    dmem_coherency_ctrl_replay_fifo #(.DEPTH(DEPTH), .W(EW)) u_q0 (
        .clk   (clk),
        .reset (reset),
        .push  (acc1),
        .push2 (acc0),
        .din   (ent1),
        .din2  (ent0),
        .pop   (~empty0),
        .dout  (head0),
        .empty (empty0),
        .full  (full0)
    );

    dmem_coherency_ctrl_replay_fifo #(.DEPTH(DEPTH), .W(EW)) u_q1 (
        .clk   (clk),
        .reset (reset),
        .push  (acc0),
        .push2 (1'b0),
        .din   (ent0),
        .din2  (ent0),
        .pop   (~empty1),
        .dout  (head1),
        .empty (empty1),
        .full  (full1)
    );

    assign rd0 = unpack_entry(MAX_ENTRY_W'(head0));
    assign rd1 = unpack_entry(MAX_ENTRY_W'(head1));

    assign dmemWrenC0  = ~empty0;
    assign aluOutMemC0 = empty0 ? '0 : rd0.addr;
    assign dataBMemC0  = empty0 ? '0 : rd0.data;
    assign funct3MemC0 = empty0 ? '0 : rd0.funct3;
    assign dmemWrenC1  = ~empty1;
    assign aluOutMemC1 = empty1 ? '0 : rd1.addr;
    assign dataBMemC1  = empty1 ? '0 : rd1.data;
    assign funct3MemC1 = empty1 ? '0 : rd1.funct3;

endmodule

// File: tb/tb_dmem_coherency_ctrl.sv
// tb_dmem_coherency_ctrl: scenario tasks drive stores and check stalls inline; a negedge monitor
// pops expected replays from per-core scoreboard queues whenever the DUT presents a mirrored write.
module tb_dmem_coherency_ctrl;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] aluOutMem0 = '0, dataBMem0 = '0, aluOutMem1 = '0, dataBMem1 = '0;
    logic [2:0]  funct3Mem0 = '0, funct3Mem1 = '0;
    logic        dmemWren0 = 1'b0, dmemWren1 = 1'b0;
    logic        extStall0, dmemWrenC0, extStall1, dmemWrenC1, busy;
    logic [31:0] aluOutMemC0, dataBMemC0, aluOutMemC1, dataBMemC1;
    logic [2:0]  funct3MemC0, funct3MemC1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];
    int  n_chk = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    dmem_coherency_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .aluOutMem0  (aluOutMem0),
        .dataBMem0   (dataBMem0),
        .funct3Mem0  (funct3Mem0),
        .dmemWren0   (dmemWren0),
        .aluOutMem1  (aluOutMem1),
        .dataBMem1   (dataBMem1),
        .funct3Mem1  (funct3Mem1),
        .dmemWren1   (dmemWren1),
        .extStall0   (extStall0),
        .aluOutMemC0 (aluOutMemC0),
        .dataBMemC0  (dataBMemC0),
        .funct3MemC0 (funct3MemC0),
        .dmemWrenC0  (dmemWrenC0),
        .extStall1   (extStall1),
        .aluOutMemC1 (aluOutMemC1),
        .dataBMemC1  (dataBMemC1),
        .funct3MemC1 (funct3MemC1),
        .dmemWrenC1  (dmemWrenC1),
        .busy        (busy)
    );

    function automatic wr_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        wr_t w;
        w.a = a & ((32'h1 << ADDR_W) - 1);
        w.d = d;
        w.f = f;
        return w;
    endfunction

    // Scoreboard: every mirrored write must match the oldest expectation for that core.
    always @(negedge clk) begin
        if (mon_en && dmemWrenC0) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL replay0: unexpected write a=%h d=%h f=%0d", aluOutMemC0, dataBMemC0, funct3MemC0);
            end else begin
                wr_t w;
                w = q0.pop_front();
                if ({aluOutMemC0, dataBMemC0, funct3MemC0} !== {w.a, w.d, w.f}) begin
                    n_fail++;
                    $display("FAIL replay0: got a=%h d=%h f=%0d, want a=%h d=%h f=%0d",
                             aluOutMemC0, dataBMemC0, funct3MemC0, w.a, w.d, w.f);
                end
            end
        end
        if (mon_en && dmemWrenC1) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL replay1: unexpected write a=%h d=%h f=%0d", aluOutMemC1, dataBMemC1, funct3MemC1);
            end else begin
                wr_t w;
                w = q1.pop_front();
                if ({aluOutMemC1, dataBMemC1, funct3MemC1} !== {w.a, w.d, w.f}) begin
                    n_fail++;
                    $display("FAIL replay1: got a=%h d=%h f=%0d, want a=%h d=%h f=%0d",
                             aluOutMemC1, dataBMemC1, funct3MemC1, w.a, w.d, w.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dmemWren0 = 1'b0;
        dmemWren1 = 1'b0;
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        aluOutMem0 = a;
        dataBMem0  = d;
        funct3Mem0 = f;
        dmemWren0  = 1'b1;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        aluOutMem1 = a;
        dataBMem1  = d;
        funct3Mem1 = f;
        dmemWren1  = 1'b1;
    endtask

    task automatic check_stall(input string name, input logic s0, input logic s1);
        n_chk++;
        if ({extStall0, extStall1} !== {s0, s1}) begin
            n_fail++;
            $display("FAIL %s: stall0/1 got %b%b want %b%b", name, extStall0, extStall1, s0, s1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            aluOutMem0 = $urandom;
            dataBMem0  = $urandom;
            funct3Mem0 = 3'($urandom);
            dmemWren0  = 1'($urandom);
            aluOutMem1 = $urandom;
            dataBMem1  = $urandom;
            funct3Mem1 = 3'($urandom);
            dmemWren1  = 1'($urandom);
            @(negedge clk);
            n_chk++;
            if ({extStall0, aluOutMemC0, dataBMemC0, funct3MemC0, dmemWrenC0, extStall1,
                 aluOutMemC1, dataBMemC1, funct3MemC1, dmemWrenC1, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: outputs not zero (stall0=%b wrC0=%b stall1=%b wrC1=%b busy=%b)",
                         extStall0, dmemWrenC0, extStall1, dmemWrenC1, busy);
            end
        end
        idle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            n_chk++;
            if ({extStall0, aluOutMemC0, dataBMemC0, funct3MemC0, dmemWrenC0, extStall1,
                 aluOutMemC1, dataBMemC1, funct3MemC1, dmemWrenC1, busy} !== '0) begin
                n_fail++;
                $display("FAIL reset_release: outputs not zero (stall0=%b wrC0=%b stall1=%b wrC1=%b busy=%b)",
                         extStall0, dmemWrenC0, extStall1, dmemWrenC1, busy);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single();
        step();
        drive0(32'h3, 32'hAB, 3'd0);
        q1.push_back(mk(32'h3, 32'hAB, 3'd0));
        @(negedge clk);
        check_stall("single_t", 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        check_stall("single_t1", 1'b0, 1'b1);
        n_chk++;
        if (dmemWrenC1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_wrC1: got %b want 1", dmemWrenC1);
        end
        step();
        @(negedge clk);
        check_stall("single_t2", 1'b0, 1'b0);
        n_chk++;
        if ({busy, dmemWrenC1} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: busy/wrC1 got %b%b want 00", busy, dmemWrenC1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            step();
            drive0(32'hFFFF_FF00 | 32'(i), 32'(i), 3'd2);
            q1.push_back(mk(32'hFFFF_FF00 | 32'(i), 32'(i), 3'd2));
            @(negedge clk);
            check_stall($sformatf("b2b_t%0d", i - 1), 1'b0, i > 1);
        end
        step();
        idle();
        @(negedge clk);
        check_stall("b2b_t3", 1'b0, 1'b1);
        step();
        @(negedge clk);
        check_stall("b2b_t4", 1'b0, 1'b0);
    endtask

    task automatic launch_collision();
        step();
        drive0(32'h2, 32'h11, 3'd2);
        drive1(32'h2, 32'h22, 3'd2);
        q1.push_back(mk(32'h2, 32'h11, 3'd2));
        q0.push_back(mk(32'h2, 32'h22, 3'd2));
        q0.push_back(mk(32'h2, 32'h11, 3'd2));
        @(negedge clk);
        check_stall("coll_t", 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        check_stall("coll_t1", 1'b1, 1'b1);
    endtask

    task automatic test_collision();
        launch_collision();
        step();
        @(negedge clk);
        check_stall("coll_t2", 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_stall("coll_t3", 1'b0, 1'b0);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_held_strobe();
        step();
        drive0(32'h5, 32'h55, 3'd1);
        q1.push_back(mk(32'h5, 32'h55, 3'd1));
        @(negedge clk);
        check_stall("held_t", 1'b0, 1'b0);
        step();
        idle();
        drive1(32'h1C7, 32'h77, 3'd2);
        @(negedge clk);
        check_stall("held_t1", 1'b0, 1'b1);
        step();
        @(negedge clk);
        check_stall("held_t2", 1'b0, 1'b0);
        q0.push_back(mk(32'h1C7, 32'h77, 3'd2));
        step();
        idle();
        @(negedge clk);
        check_stall("held_t3", 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_stall("held_t4", 1'b0, 1'b0);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_replay();
        launch_collision();
        #2;
        reset = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        n_chk++;
        if ({extStall0, aluOutMemC0, dataBMemC0, funct3MemC0, dmemWrenC0, extStall1,
             aluOutMemC1, dataBMemC1, funct3MemC1, dmemWrenC1, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs not zero (stall0=%b wrC0=%b stall1=%b wrC1=%b busy=%b)",
                     extStall0, dmemWrenC0, extStall1, dmemWrenC1, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            n_chk++;
            if ({busy, dmemWrenC0, dmemWrenC1, extStall0, extStall1} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after%0d: busy/wrC0/wrC1/stall0/stall1 got %b%b%b%b%b want 00000",
                         i, busy, dmemWrenC0, dmemWrenC1, extStall0, extStall1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_held_strobe();
        test_reset_mid_replay();
        n_chk++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending expectations q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_coherency_ctrl.md
Name: dmem_coherency_ctrl

Overview:
- Keeps the private data memories of the two rv32i cores coherent by write-replay.
- Captures every store committed by either core's memory stage into a replay queue toward the other core.
- Drains each queue one entry per cycle: stalls the target core via extStall and drives that core's coherency inlet (aluOutMemC/dataBMemC/funct3MemC/dmemWrenC), so its DMEM performs the mirrored write.
- Sits at top level between core 0 and core 1; there is one instance per core pair.

Parameters:
- DEPTH, 4: entries per replay queue; legal range is DEPTH >= 2.
- ADDR_W, 8: low bits of aluOutMem kept as the replay address; upper bits are driven as zero.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- aluOutMem0  input  32  core 0 memory-stage address
- dataBMem0  input  32  core 0 store data
- funct3Mem0  input  3  core 0 store size
- dmemWren0  input  1  core 0 store strobe
- aluOutMem1 / dataBMem1 / funct3Mem1 / dmemWren1  input  32/32/3/1  same four signals for core 1
- extStall0  output  1  freezes core 0; while high, core 0's DMEM takes the C inlet
- aluOutMemC0 / dataBMemC0 / funct3MemC0 / dmemWrenC0  output  32/32/3/1  replay write into core 0
- extStall1 / aluOutMemC1 / dataBMemC1 / funct3MemC1 / dmemWrenC1  output  1/32/32/3/1  replay write into core 1
- busy  output  1  either queue non-empty

Behaviour:
- Queue Qn holds writes destined for core n.
  - Entry = {addr[ADDR_W-1:0], data[31:0], funct3[2:0]}.
  - Each queue is a circular buffer with wrapping read/write pointers and a count.
- Stall equations (combinational from registered state only; no input-to-output path):
  - extStall0 = ~empty(Q0) | full(Q1)
  - extStall1 = ~empty(Q1) | full(Q0)
- Capture rules:
  - A core-0 store is accepted when dmemWren0 & ~extStall0 in the same cycle. The entry built from {aluOutMem0, dataBMem0, funct3Mem0} is pushed into Q1 at that edge.
  - Core-1 stores are accepted and pushed into Q0 symmetrically.
  - A strobe held high while its core is stalled is not captured. It is captured exactly once, in the first unstalled cycle.
- Replay outputs: while Qn is non-empty, the following are driven from the head of Qn.
  - dmemWrenCn = 1
  - aluOutMemCn = zero-extended addr
  - dataBMemCn = data
  - funct3MemCn = funct3
  - The head is popped at the clock edge.
  - When Qn is empty, all Cn outputs are 0.
  - Latency: store accepted at edge t, mirrored write presented during cycle t+1.
- Push and pop on the same queue in one cycle: count is unchanged and both pointers advance.
- Simultaneous stores (both cores accepted in the same cycle, which is only possible when both queues are empty):
  - Core 0 has priority.
  - Q1 receives core 0's entry.
  - Q0 receives core 1's entry, then core 0's entry, as a double push in one edge.
  - Result: both memories end holding core 0's value, independent of address overlap.
  - A double push always targets an empty queue, so DEPTH >= 2 suffices.
- Full: a full destination queue stalls the source core. No push is ever dropped, and a push into a full queue never occurs.
- Reset (asynchronous, any time including mid-replay):
  - All pointers and counts go to 0.
  - All outputs go to 0.
  - Pending replays are discarded.
  - The first cycle after release is idle.
- busy = ~empty(Q0) | ~empty(Q1).

Decomposition:
- Shared package holds:
  - ENTRY_W = ADDR_W+35
  - Field offset constants
  - A pack/unpack function for the queue entry.
- Natural sub-module: replay_fifo, instantiated twice.
  - Ports: clk, reset, push, push2, din, din2, pop, dout, empty, full.
  - The top level holds capture, collision and stall logic.

Test Plan:
1. Reset held low with random inputs -> every output is 0 and busy=0; after release, all outputs remain 0 with dmemWren0/1=0.
2. Core 0 sb at t (aluOutMem0=3, dataBMem0=0xAB, funct3Mem0=0) -> cycle t+1: extStall1=1, dmemWrenC1=1, aluOutMemC1=3, dataBMemC1=0xAB, funct3MemC1=0; t+2: extStall1=0, extStall0=0 throughout.
3. Core 0 stores at t, t+1, t+2 (data 1, 2, 3) -> extStall1 high t+1..t+3 with dataBMemC1=1, 2, 3 in order; Q1 count never exceeds 1.
4. Collision at t, both sw to addr 2 (core 0 0x11, core 1 0x22) -> t+1: C1 writes 0x11, C0 writes 0x22; t+2: C0 writes 0x11; extStall0 high t+1..t+2, extStall1 high t+1 only. With DEPTH=2, extStall1 is also high at t+1 due to full(Q0).
5. Core 1 holds dmemWren1=1 during its replay stall (t+1) -> no capture at t+1; single capture at t+2; Q0 receives exactly one entry.
6. reset pulsed low during cycle t+1 of scenario 4 -> all outputs 0 immediately; after release, no residual replay and busy=0.
